// File: rtl/period_meter.sv
// period_meter: measures the period and high time of a slow, asynchronous
// signal in clk_in cycles. One result per input period, announced by a
// one-cycle valid strobe. A sticky overflow flag records a period that ran
// past max_count.
//
// Handshake: valid is a one-cycle strobe with no ready. period_out/high_out
// are valid in the cycle valid is high and hold until the next strobe.
// Parameter constraints: 2 <= max_count <= 2**width-1, sync_stages >= 2.
module period_meter #(
    parameter int width       = 23,
    parameter int max_count   = 8388607,
    parameter int sync_stages = 2
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             enable,
    output logic [width-1:0] period_out,
    output logic [width-1:0] high_out,
    output logic             valid,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam logic [width-1:0] MAX_C = width'(max_count);
    localparam logic [width-1:0] ONE   = width'(1);

    state_t                 state_q, state_d;
    logic [sync_stages-1:0] sync_q, sync_d;
    logic                   edge_q, edge_d;
    logic [width-1:0]       count_q, count_d;
    logic [width-1:0]       hcount_q, hcount_d;
    logic [width-1:0]       period_q, period_d;
    logic [width-1:0]       high_q, high_d;
    logic                   valid_q, valid_d;
    logic                   overflow_q, overflow_d;
    logic                   busy_q, busy_d;

    // Synchronised level and its rising edge. Synchroniser latency is the
    // same for every edge, so it cancels out of both measurements.
    logic s;
    logic rise;

    // Synchroniser shift chain plus the edge register behind it.
    always_comb begin
        sync_d = {sync_q[sync_stages-2:0], sig_in};
        edge_d = sync_q[sync_stages-1];
        s      = sync_q[sync_stages-1];
        rise   = s & ~edge_q;
    end

    // Measurement FSM next-state and result logic.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        hcount_d   = hcount_q;
        period_d   = period_q;
        high_d     = high_q;
        valid_d    = 1'b0;
        overflow_d = overflow_q;

        if (!enable) begin
            // Dropping enable abandons any partial period; results and the
            // overflow flag are left untouched.
            state_d  = IDLE;
            count_d  = '0;
            hcount_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    count_d  = '0;
                    hcount_d = '0;
                    state_d  = ARM;
                end
                ARM: begin
                    // Edge-triggered: a signal already high here is ignored.
                    if (rise) begin
                        count_d  = ONE;
                        hcount_d = ONE;
                        state_d  = MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        // Rise wins over the limit, so a period of exactly
                        // max_count is reported rather than flagged.
                        period_d   = count_q;
                        high_d     = hcount_q;
                        valid_d    = 1'b1;
                        overflow_d = 1'b0;
                        count_d    = ONE;
                        hcount_d   = ONE;
                    end else if (count_q == MAX_C) begin
                        overflow_d = 1'b1;
                        state_d    = ARM;
                    end else begin
                        count_d  = count_q + ONE;
                        // hcount trails count, so it cannot wrap.
                        hcount_d = hcount_q + {{(width-1){1'b0}}, s};
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset overrides everything.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q    <= IDLE;
            sync_q     <= '0;
            edge_q     <= 1'b0;
            count_q    <= '0;
            hcount_q   <= '0;
            period_q   <= '0;
            high_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            edge_q     <= edge_d;
            count_q    <= count_d;
            hcount_q   <= hcount_d;
            period_q   <= period_d;
            high_q     <= high_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
        end
    end

    assign period_out = period_q;
    assign high_out   = high_q;
    assign valid      = valid_q;
    assign overflow   = overflow_q;
    assign busy       = busy_q;

endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Measures the period and high time of a slow external signal, in clk_in cycles. It is the receive-side counterpart of the team's tick/divider generators: those turn a count into a waveform, this turns a waveform back into a count.
- Used to close the loop on divided clocks and to characterise evolved circuit outputs in the overlay.
- Reports one result per input period, with a 1-cycle valid strobe and a sticky overflow flag.

Parameters:
- width, 23, bit width of the counters and result outputs.
- max_count, 8388607, longest measurable period in clk_in cycles; must be ≤ 2^width−1 and ≥ 2.
- sync_stages, 2, length of the sig_in synchroniser chain; must be ≥ 2.

Ports:
- clk_in  in  1  sole clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- sig_in  in  1  asynchronous signal to be measured.
- enable  in  1  measurement enable, level-sensitive.
- period_out  out  width  clk_in cycles between the last two rising edges of sig_in.
- high_out  out  width  cycles sig_in was high within that period.
- valid  out  1  1-cycle strobe; new period_out/high_out are present in the same cycle.
- overflow  out  1  sticky; set when a timeout occurs.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Synchroniser:
  - sig_in passes through sync_stages flops, then one edge register.
  - rise = last sync flop & ~edge register.
  - s = the last sync flop.
  - Latency is constant, so it cancels out of both measurements.
  - reset clears all sync flops and the edge register to 0.
- Reset:
  - state=IDLE.
  - count=0, hcount=0.
  - period_out=0, high_out=0, valid=0, overflow=0.
- FSM has states IDLE, ARM, MEASURE; enable low in any state forces IDLE next cycle.
- IDLE:
  - count and hcount cleared.
  - Moves to ARM when enable=1.
- ARM:
  - Waits for rise; it is edge-triggered, so a signal already high when ARM is entered is not counted.
  - On rise: count<=1, hcount<=1, go to MEASURE.
- MEASURE, rise this cycle:
  - period_out<=count, high_out<=hcount, valid<=1, overflow<=0.
  - count<=1, hcount<=1, stay in MEASURE (back-to-back measurement, no dead cycle).
- MEASURE, no rise and count==max_count:
  - overflow<=1, go to ARM; no valid is issued.
- MEASURE, no rise otherwise:
  - count<=count+1, hcount<=hcount+s.
- Timing of results:
  - valid is registered; it asserts exactly one cycle after the rise-detect cycle and is deasserted in every other cycle.
  - period_out/high_out hold their last value until the next valid.
- Required arithmetic: for a periodic sig_in of P cycles with H cycles high, period_out=P and high_out=H.
- Boundaries:
  - The first rise after enable only arms the block; the first valid follows the second rise.
  - rise coinciding with count==max_count: rise wins, so a period of exactly max_count is reported and is not an overflow.
  - Minimum period is 2 (result period_out=2, high_out=1).
  - hcount never exceeds count, so it cannot overflow.
  - enable dropping mid-period discards the partial measurement: no valid, outputs hold their last values, overflow is unchanged.
  - overflow clears only on the next valid or on reset.
  - reset mid-operation takes priority over everything: all outputs read 0 in the next cycle.

Test Plan:
- Period and duty: enable=1, sig_in period 10 with 3 high (synchronous). Expect the first valid after the 2nd rise, then valid every 10 cycles with period_out=10, high_out=3, overflow=0.
- Fastest input: sig_in toggling every cycle. Expect period_out=2, high_out=1, valid every 2 cycles, and busy held high.
- Timeout (max_count=16): one rise, then sig_in held low. Expect overflow=1 exactly 16 cycles after the arming rise's count<=1, state=ARM, and no valid. A subsequent period-8 input produces valid with period_out=8 and clears overflow.
- Exact limit (max_count=16): period 16 input. Expect valid with period_out=16, overflow=0.
- Enable dropped mid-period: enable low 5 cycles into a period. Expect no valid, busy=0 the next cycle, outputs unchanged. Re-enabling needs two more rises before the next valid.
- Reset mid-measurement: assert reset for 1 cycle during MEASURE. Expect period_out=0, high_out=0, valid=0, overflow=0, busy=0 the next cycle; a held-high sig_in only arms the block.
